mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master, one-slave arbiter that shares the single instruction/data memory port between the fetch stage (`if_*`) and the memory-access stage (`data_*`). It sits between the pipeline and the memory model, serialises requests using the `ce`/`ack` handshake, and raises `stallreq` toward the pipeline controller while any master is waiting. A watchdog terminates transfers the slave never acknowledges.

## Interface
- `AddrWidth`, 32, address width of all ports
- `DataWidth`, 32, data width of all ports
- `TimeoutCycles`, 255, cycles in a grant state without `mem_ack` before forced termination (≥2, fits 8 bits)

- `clk` in 1: single clock, all state updates on rising edge
- `rst` in 1: synchronous, active-high reset
- `if_req` in 1: fetch request, held high until `if_ack`
- `if_addr` in AddrWidth: fetch address
- `if_rdata` out DataWidth: fetch read data, valid when `if_ack`
- `if_ack` out 1: one-cycle completion pulse for fetch
- `data_req` in 1: data request, held high until `data_ack`
- `data_we` in 1: 1 = write, 0 = read
- `data_addr` in AddrWidth: data address
- `data_wdata` in DataWidth: write data
- `data_sel` in 4: byte enables
- `data_rdata` out DataWidth: data read data, valid when `data_ack`
- `data_ack` out 1: one-cycle completion pulse for data
- `mem_ce`, `mem_we` out 1: slave chip enable / write enable
- `mem_addr` out AddrWidth; `mem_wdata` out DataWidth; `mem_sel` out 4: slave request fields
- `mem_rdata` in DataWidth; `mem_ack` in 1: slave response (may be combinational from `mem_ce`)
- `stallreq` out 1: pipeline stall request
- `bus_err` out 1: high with the ack of a timed-out transfer

## Operation
- States: IDLE, GNT_IF, GNT_DATA. Registered `last` (0 = IF, 1 = DATA) records the most recently granted master.
- IDLE: only `if_req` → GNT_IF; only `data_req` → GNT_DATA; both → grant the master ≠ `last`; none → stay.
- Grant states: `mem_ce` = 1; `mem_addr/we/wdata/sel` driven from the granted master's inputs (IF: `mem_we` = 0, `mem_sel` = 4'hF, `mem_wdata` = 0). In IDLE all `mem_*` outputs are 0.
- Grant ends on the edge where `mem_ack` = 1: that cycle the granted master's `*_ack` = 1 and `*_rdata` = `mem_rdata` (combinational pass-through); next state IDLE, `last` updated. No preemption.
- Watchdog: 8-bit counter cleared on entering a grant, +1 per grant cycle without `mem_ack`. When it reaches `TimeoutCycles - 1` with no `mem_ack`, that cycle issues the master's ack with rdata = 0 and `bus_err` = 1, then IDLE. A `mem_ack` arriving the same cycle wins (normal completion, `bus_err` = 0).
- Non-granted master: ack = 0, rdata = 0.
- `stallreq` = (`if_req` & ~`if_ack`) | (`data_req` & ~`data_ack`).
- Request withdrawn mid-grant is a protocol violation; the arbiter still finishes the transfer and pulses the ack.

## Timing
- Reset: state IDLE, `last` = 0 (data wins first tie), counter 0; thus all `mem_*`, acks, rdata, `bus_err` = 0. `stallreq` follows inputs combinationally.
- `rst` during a grant: next edge IDLE, `mem_ce` = 0, no ack issued.
- Latency with zero-wait slave: request sampled at edge N, `mem_ce` and ack in cycle N+1, IDLE at N+2. Each transfer occupies ≥2 cycles; back-to-back grants have one IDLE cycle between.
- Both masters continuously requesting: grants alternate DATA, IF, DATA, ...; each served within 4 cycles with a zero-wait slave.
- Slave with k wait states: ack in cycle N+1+k.

## Test plan
- Reset, then `if_req`=1, `if_addr`=0x0000_0004, zero-wait slave returning 0x3401_1100 → `mem_ce`=1 next cycle, `if_ack`=1 with `if_rdata`=0x3401_1100, `stallreq` high in request cycle only.
- `if_req` and `data_req` rise together after reset → DATA granted first, IF second; `mem_addr` sequence data_addr, 0, if_addr; `last` toggles.
- Data write `data_addr`=0x100, `data_wdata`=0xDEADBEEF, `data_sel`=4'b0011, slave 3 wait states → `mem_we`=1, `mem_sel`=0011 held 4 cycles, `data_ack` on 4th.
- Slave never acks, `TimeoutCycles`=8 → ack with `bus_err`=1, rdata 0, exactly 8 cycles after grant; `mem_ack` forced in cycle 8 instead → `bus_err`=0.
- `rst` pulsed during a 5-wait-state IF grant → `mem_ce`=0 next cycle, no `if_ack`; after release, fresh grant starts.
- Both masters held high 20 cycles, zero-wait slave → strict alternation, 5 grants each, no master waits >4 cycles.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Two-master (fetch / data) to one-slave memory port arbiter with
//            alternating priority on ties, ce/ack handshake, pipeline stall
//            request and a watchdog that terminates unacknowledged transfers.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int AddrWidth     = 32,
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  // fetch master
  input  logic                 if_req_i,
  input  logic [AddrWidth-1:0] if_addr_i,
  output logic [DataWidth-1:0] if_rdata_o,
  output logic                 if_ack_o,
  // data master
  input  logic                 data_req_i,
  input  logic                 data_we_i,
  input  logic [AddrWidth-1:0] data_addr_i,
  input  logic [DataWidth-1:0] data_wdata_i,
  input  logic [3:0]           data_sel_i,
  output logic [DataWidth-1:0] data_rdata_o,
  output logic                 data_ack_o,
  // memory slave
  output logic                 mem_ce_o,
  output logic                 mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  output logic [3:0]           mem_sel_o,
  input  logic [DataWidth-1:0] mem_rdata_i,
  input  logic                 mem_ack_i,
  // pipeline control
  output logic                 stallreq_o,
  output logic                 bus_err_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_IF   = 2'd1,
    GNT_DATA = 2'd2
  } state_t;

  // Watchdog fires on the cycle the counter holds this value.
  localparam logic [7:0] TimeoutLast = 8'(TimeoutCycles - 1);

  state_t     state_q, state_d;
  logic       last_q, last_d;   // 0 = fetch granted last, 1 = data granted last
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_w;

  // State, priority bit and watchdog counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // A real slave ack in the same cycle always beats the watchdog.
  assign timeout_w = (cnt_q == TimeoutLast) && !mem_ack_i;

  // Next-state, slave port muxing and master responses.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    mem_ce_o     = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_sel_o    = 4'h0;
    if_ack_o     = 1'b0;
    if_rdata_o   = '0;
    data_ack_o   = 1'b0;
    data_rdata_o = '0;
    bus_err_o    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (if_req_i && data_req_i) begin
          state_d = last_q ? GNT_IF : GNT_DATA;
        end else if (if_req_i) begin
          state_d = GNT_IF;
        end else if (data_req_i) begin
          state_d = GNT_DATA;
        end
      end

      GNT_IF: begin
        mem_ce_o   = 1'b1;
        mem_addr_o = if_addr_i;
        mem_sel_o  = 4'hF;
        if (mem_ack_i) begin
          if_ack_o   = 1'b1;
          if_rdata_o = mem_rdata_i;
          state_d    = IDLE;
          last_d     = 1'b0;
        end else if (timeout_w) begin
          if_ack_o  = 1'b1;
          bus_err_o = 1'b1;
          state_d   = IDLE;
          last_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      GNT_DATA: begin
        mem_ce_o    = 1'b1;
        mem_we_o    = data_we_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
        mem_sel_o   = data_sel_i;
        if (mem_ack_i) begin
          data_ack_o   = 1'b1;
          data_rdata_o = mem_rdata_i;
          state_d      = IDLE;
          last_d       = 1'b1;
        end else if (timeout_w) begin
          data_ack_o = 1'b1;
          bus_err_o  = 1'b1;
          state_d    = IDLE;
          last_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Stall while any master has a request that is not completing this cycle.
  assign stallreq_o = (if_req_i && !if_ack_o) || (data_req_i && !data_ack_o);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed self-checking bench for mem_arbiter with a wait-state
//            programmable slave model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_sel;
  logic [31:0] data_rdata;
  logic        data_ack;
  logic        mem_ce;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_sel;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stallreq;
  logic        bus_err;

  // slave model controls
  logic        slave_en;
  logic        force_ack;
  logic [3:0]  ws_target;
  logic [3:0]  ws_cnt;

  int n_checks = 0;
  int n_errors = 0;
  int n_data   = 0;
  int n_if     = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .AddrWidth    (32),
    .DataWidth    (32),
    .TimeoutCycles(8)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req),
    .if_addr_i   (if_addr),
    .if_rdata_o  (if_rdata),
    .if_ack_o    (if_ack),
    .data_req_i  (data_req),
    .data_we_i   (data_we),
    .data_addr_i (data_addr),
    .data_wdata_i(data_wdata),
    .data_sel_i  (data_sel),
    .data_rdata_o(data_rdata),
    .data_ack_o  (data_ack),
    .mem_ce_o    (mem_ce),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_sel_o   (mem_sel),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (mem_ack),
    .stallreq_o  (stallreq),
    .bus_err_o   (bus_err)
  );

  // Slave: acks after ws_target wait cycles, or only when forced.
  always_comb begin
    mem_ack = 1'b0;
    if (mem_ce) mem_ack = slave_en ? (ws_cnt == ws_target) : force_ack;
  end

  always @(posedge clk) begin
    if (!mem_ce || mem_ack) ws_cnt <= 4'd0;
    else                    ws_cnt <= ws_cnt + 4'd1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; if_req = 0; if_addr = 0; data_req = 0; data_we = 0;
    data_addr = 0; data_wdata = 0; data_sel = 0; mem_rdata = 0;
    slave_en = 1; force_ack = 0; ws_target = 0;
    cyc(); cyc();
    settle();
    chk("rst_ce",       {31'd0, mem_ce},   32'd0);
    chk("rst_addr",     mem_addr,          32'd0);
    chk("rst_ifack",    {31'd0, if_ack},   32'd0);
    chk("rst_dack",     {31'd0, data_ack}, 32'd0);
    chk("rst_berr",     {31'd0, bus_err},  32'd0);
    chk("rst_stall",    {31'd0, stallreq}, 32'd0);

    // ---- single fetch, zero-wait slave
    cyc(); rst = 0;
    cyc();
    if_req = 1; if_addr = 32'h0000_0004; mem_rdata = 32'h3401_1100; settle();
    chk("t1_req_stall", {31'd0, stallreq}, 32'd1);
    chk("t1_req_ce",    {31'd0, mem_ce},   32'd0);
    cyc(); settle();
    chk("t1_ce",        {31'd0, mem_ce},   32'd1);
    chk("t1_addr",      mem_addr,          32'h4);
    chk("t1_sel",       {28'd0, mem_sel},  32'hF);
    chk("t1_we",        {31'd0, mem_we},   32'd0);
    chk("t1_ack",       {31'd0, if_ack},   32'd1);
    chk("t1_rdata",     if_rdata,          32'h3401_1100);
    chk("t1_stall",     {31'd0, stallreq}, 32'd0);
    cyc(); if_req = 0; settle();
    chk("t1_idle_ce",   {31'd0, mem_ce},   32'd0);
    chk("t1_idle_ack",  {31'd0, if_ack},   32'd0);

    // ---- simultaneous requests: data first (last = IF)
    cyc();
    if_req = 1; if_addr = 32'h8; data_req = 1; data_addr = 32'h200; data_we = 0;
    data_sel = 4'hF; mem_rdata = 32'hCAFE_0001; settle();
    chk("t2_a0", mem_addr, 32'h0);
    cyc(); settle();
    chk("t2_a1",     mem_addr,                  32'h200);
    chk("t2_dack",   {31'd0, data_ack},         32'd1);
    chk("t2_drd",    data_rdata,                32'hCAFE_0001);
    chk("t2_ifrd0",  if_rdata,                  32'd0);
    chk("t2_ifack0", {31'd0, if_ack},           32'd0);
    chk("t2_stall1", {31'd0, stallreq},         32'd1);
    cyc(); data_req = 0; settle();
    chk("t2_a2",     mem_addr,                  32'h0);
    chk("t2_stall2", {31'd0, stallreq},         32'd1);
    cyc(); mem_rdata = 32'hCAFE_0002; settle();
    chk("t2_a3",     mem_addr,                  32'h8);
    chk("t2_ifack",  {31'd0, if_ack},           32'd1);
    chk("t2_ifrd",   if_rdata,                  32'hCAFE_0002);
    chk("t2_drd0",   data_rdata,                32'd0);
    cyc(); if_req = 0; settle();
    chk("t2_idle",   {31'd0, mem_ce},           32'd0);

    // ---- data write with 3 wait states
    cyc();
    ws_target = 3; data_req = 1; data_we = 1; data_addr = 32'h100;
    data_wdata = 32'hDEAD_BEEF; data_sel = 4'b0011;
    cyc();
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("t3_ce",    {31'd0, mem_ce},   32'd1);
      chk("t3_we",    {31'd0, mem_we},   32'd1);
      chk("t3_sel",   {28'd0, mem_sel},  32'h3);
      chk("t3_addr",  mem_addr,          32'h100);
      chk("t3_wdata", mem_wdata,         32'hDEAD_BEEF);
      chk("t3_ack",   {31'd0, data_ack}, (i == 3) ? 32'd1 : 32'd0);
      if (i < 3) cyc();
    end
    cyc(); data_req = 0; data_we = 0; settle();
    chk("t3_idle", {31'd0, mem_ce}, 32'd0);

    // ---- watchdog: slave never acks
    cyc();
    slave_en = 0; if_req = 1; if_addr = 32'hC;
    cyc();
    for (int i = 1; i <= 8; i++) begin
      settle();
      chk("t4_ce",   {31'd0, mem_ce},  32'd1);
      chk("t4_ack",  {31'd0, if_ack},  (i == 8) ? 32'd1 : 32'd0);
      chk("t4_berr", {31'd0, bus_err}, (i == 8) ? 32'd1 : 32'd0);
      chk("t4_rd",   if_rdata,         32'd0);
      if (i < 8) cyc();
    end
    cyc(); if_req = 0; settle();
    chk("t4_idle", {31'd0, mem_ce}, 32'd0);

    // ---- watchdog boundary: real ack in cycle 8 wins
    cyc();
    data_req = 1; data_addr = 32'h44; mem_rdata = 32'h1234_5678;
    cyc();
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) force_ack = 1;
      settle();
      chk("t4b_ack",  {31'd0, data_ack}, (i == 8) ? 32'd1 : 32'd0);
      chk("t4b_berr", {31'd0, bus_err},  32'd0);
      if (i < 8) cyc();
    end
    chk("t4b_rd", data_rdata, 32'h1234_5678);
    cyc(); force_ack = 0; data_req = 0; slave_en = 1; settle();
    chk("t4b_idle", {31'd0, mem_ce}, 32'd0);

    // ---- reset during a 5-wait-state fetch grant
    cyc();
    ws_target = 5; if_req = 1; if_addr = 32'h50; mem_rdata = 32'hABCD_0000;
    cyc(); settle();
    chk("t5_ce1", {31'd0, mem_ce}, 32'd1);
    cyc(); rst = 1; settle();
    chk("t5_noack", {31'd0, if_ack}, 32'd0);
    cyc(); rst = 0; settle();
    chk("t5_ce0",    {31'd0, mem_ce}, 32'd0);
    chk("t5_noack2", {31'd0, if_ack}, 32'd0);
    cyc();
    for (int i = 0; i < 6; i++) begin
      settle();
      chk("t5_ce",   {31'd0, mem_ce}, 32'd1);
      chk("t5_addr", mem_addr,        32'h50);
      chk("t5_ack",  {31'd0, if_ack}, (i == 5) ? 32'd1 : 32'd0);
      if (i < 5) cyc();
    end
    chk("t5_rd", if_rdata, 32'hABCD_0000);
    cyc(); if_req = 0; ws_target = 0; settle();
    chk("t5_idle", {31'd0, mem_ce}, 32'd0);

    // ---- both masters held for 20 cycles: strict alternation DATA, IF, ...
    cyc();
    if_req = 1; data_req = 1; data_we = 0; if_addr = 32'h60; data_addr = 32'h70;
    for (int c = 0; c < 20; c++) begin
      settle();
      chk("t6_dack", {31'd0, data_ack}, (c % 4 == 1) ? 32'd1 : 32'd0);
      chk("t6_iack", {31'd0, if_ack},   (c % 4 == 3) ? 32'd1 : 32'd0);
      if (data_ack) n_data++;
      if (if_ack)   n_if++;
      cyc();
    end
    chk("t6_ndata", n_data, 32'd5);
    chk("t6_nif",   n_if,   32'd5);
    if_req = 0; data_req = 0;
    cyc(); cyc(); settle();
    chk("t6_idle", {31'd0, mem_ce}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Hard time bound so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
